// File: rtl/riscv_pc_pkg.sv
// Shared definitions for the fetch PC redirect logic: RV32 control-flow
// opcodes, the fetch FSM state encoding and the sequential PC increment.
package riscv_pc_pkg;

   localparam logic [6:0]  OP_BRANCH = 7'b1100011;
   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;

   localparam logic [31:0] PC_STEP   = 32'd4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pc_state_t;

endpackage : riscv_pc_pkg

// File: rtl/pc_target_calc.sv
// Combinational control-flow decode and redirect target computation for the
// execute-stage instruction. The JALR target has bit 0 cleared here; any
// further alignment handling is left to the caller.
module pc_target_calc
   import riscv_pc_pkg::*;
(
   input  logic [6:0]  opcode,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_imm,
   input  logic [31:0] ex_rs1Data,
   output logic [31:0] target,
   output logic        is_jal,
   output logic        is_jalr,
   output logic        is_branch
);

   // Decode the opcode class and pick the matching target adder
   always_comb begin
      is_branch = (opcode == OP_BRANCH);
      is_jal    = (opcode == OP_JAL);
      is_jalr   = (opcode == OP_JALR);
      if (is_jalr) begin
         target = (ex_rs1Data + ex_imm) & ~32'h1;
      end else begin
         target = ex_pc + ex_imm;
      end
   end

endmodule : pc_target_calc

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator. Issues the fetch PC through a valid/ready handshake,
// honours hazard stalls, and on a taken branch / JAL / JALR loads the target
// and spends one FLUSH cycle (flush=1, pc_valid=0) squashing wrong-path fetches.
// Optional build macro PC_MISALIGN_TRAP_EN: a misaligned redirect target
// sends the PC to TRAP_VEC and reports it on misalign/bad_addr. Without it the
// two low target bits are simply cleared.
module pc_redirect_unit
   import riscv_pc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
`ifdef PC_MISALIGN_TRAP_EN
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
`endif
   parameter int          XLEN     = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            imem_ready,
   input  logic            stall,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [31:0]     ex_instruction,
   input  logic [XLEN-1:0] ex_imm,
   input  logic [XLEN-1:0] ex_rs1Data,
   input  logic            Branch,
   output logic [XLEN-1:0] pc,
   output logic            pc_valid,
   output logic            flush,
   output logic [15:0]     redirect_cnt
`ifdef PC_MISALIGN_TRAP_EN
   ,
   output logic            misalign,
   output logic [XLEN-1:0] bad_addr
`endif
);

   // Only the RV32 datapath is implemented.
   generate
      if (XLEN != 32) begin : g_bad_xlen
         $error("pc_redirect_unit supports XLEN=32 only");
      end
   endgenerate

   pc_state_t   state_reg;
   logic [31:0] pc_reg;
   logic        pc_valid_reg;
   logic        flush_reg;
   logic [15:0] redirect_cnt_reg;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] target_raw;
   logic [31:0] target_next;
   logic        is_jal;
   logic        is_jalr;
   logic        is_branch;
   logic        redir;

   // Instruction fields outside opcode/funct3 play no part in redirect decode.
   logic        unused_instr_bits;

   assign opcode            = ex_instruction[6:0];
   assign funct3            = ex_instruction[14:12];
   assign unused_instr_bits = ^{ex_instruction[31:15], ex_instruction[11:7]};

   pc_target_calc u_target_calc (
      .opcode     (opcode),
      .ex_pc      (ex_pc),
      .ex_imm     (ex_imm),
      .ex_rs1Data (ex_rs1Data),
      .target     (target_raw),
      .is_jal     (is_jal),
      .is_jalr    (is_jalr),
      .is_branch  (is_branch)
   );

   // JALR is only a jump when funct3 is zero; a branch opcode needs the
   // condition result, and a Branch flag on any other opcode is ignored.
   assign redir = ex_valid & (is_jal | (is_jalr & (funct3 == 3'b000)) | (is_branch & Branch));

`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign_reg;
   logic [31:0] bad_addr_reg;
   logic        target_misaligned;

   assign target_misaligned = (target_raw[1:0] != 2'b00);
   assign target_next       = target_misaligned ? TRAP_VEC : target_raw;
   assign misalign          = misalign_reg;
   assign bad_addr          = bad_addr_reg;

   // Misalign report: pulse alongside flush, latch the offending target
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_reg <= 1'b0;
         bad_addr_reg <= 32'h0;
      end else if (state_reg == RUN && redir) begin
         misalign_reg <= target_misaligned;
         if (target_misaligned) begin
            bad_addr_reg <= target_raw;
         end
      end else begin
         misalign_reg <= 1'b0;
      end
   end
`else
   logic unused_target_lsbs;

   assign unused_target_lsbs = |target_raw[1:0];
   assign target_next        = {target_raw[31:2], 2'b00};
`endif

   // Fetch FSM, PC register and saturating redirect counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= BOOT;
         pc_reg           <= RESET_PC;
         pc_valid_reg     <= 1'b0;
         flush_reg        <= 1'b0;
         redirect_cnt_reg <= 16'h0000;
      end else begin
         case (state_reg)
            BOOT: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
               flush_reg    <= 1'b0;
            end
            RUN: begin
               if (redir) begin
                  pc_reg       <= target_next;
                  state_reg    <= FLUSH;
                  pc_valid_reg <= 1'b0;
                  flush_reg    <= 1'b1;
                  if (redirect_cnt_reg != 16'hFFFF) begin
                     redirect_cnt_reg <= redirect_cnt_reg + 16'd1;
                  end
               end else if (stall) begin
                  pc_valid_reg <= 1'b1;
               end else if (imem_ready) begin
                  pc_reg       <= pc_reg + PC_STEP;
                  pc_valid_reg <= 1'b1;
               end
            end
            FLUSH: begin
               state_reg    <= RUN;
               pc_valid_reg <= 1'b1;
               flush_reg    <= 1'b0;
            end
            default: begin
               state_reg    <= BOOT;
               pc_valid_reg <= 1'b0;
               flush_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign pc           = pc_reg;
   assign pc_valid     = pc_valid_reg;
   assign flush        = flush_reg;
   assign redirect_cnt = redirect_cnt_reg;

endmodule : pc_redirect_unit

// File: tb/tb_pc_redirect_unit.sv
// Directed testbench for pc_redirect_unit. Inputs change 1 time unit after a
// rising edge; outputs are checked at that same point, away from the edge.
// Builds with or without PC_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_pc_redirect_unit;

   localparam logic [31:0] I_BEQ     = 32'h0000_0063;
   localparam logic [31:0] I_JAL     = 32'h0000_006F;
   localparam logic [31:0] I_JALR    = 32'h0000_0067;
   localparam logic [31:0] I_JALR_F1 = 32'h0000_1067;
   localparam logic [31:0] I_ADDI    = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_ready;
   logic        stall;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] ex_instruction;
   logic [31:0] ex_imm;
   logic [31:0] ex_rs1Data;
   logic        Branch;
   logic [31:0] pc;
   logic        pc_valid;
   logic        flush;
   logic [15:0] redirect_cnt;
`ifdef PC_MISALIGN_TRAP_EN
   logic        misalign;
   logic [31:0] bad_addr;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   pc_redirect_unit dut (
      .clk            (clk),
      .rst            (rst),
      .imem_ready     (imem_ready),
      .stall          (stall),
      .ex_valid       (ex_valid),
      .ex_pc          (ex_pc),
      .ex_instruction (ex_instruction),
      .ex_imm         (ex_imm),
      .ex_rs1Data     (ex_rs1Data),
      .Branch         (Branch),
      .pc             (pc),
      .pc_valid       (pc_valid),
      .flush          (flush),
      .redirect_cnt   (redirect_cnt)
`ifdef PC_MISALIGN_TRAP_EN
      ,
      .misalign       (misalign),
      .bad_addr       (bad_addr)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid       = 1'b0;
      ex_pc          = 32'h0;
      ex_instruction = 32'h0;
      ex_imm         = 32'h0;
      ex_rs1Data     = 32'h0;
      Branch         = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0; clear_ex();
      tick(); tick();
      rst = 1'b0; imem_ready = 1'b1;
      n_checks++;
      if (pc !== 32'h0 || pc_valid !== 1'b0 || flush !== 1'b0 || redirect_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_state: pc=%h valid=%b flush=%b cnt=%h, want pc=0 valid=0 flush=0 cnt=0",
                  pc, pc_valid, flush, redirect_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_seq[%0d]: pc=%h valid=%b, want pc=%h valid=1", i, pc, pc_valid, exp_pc[i]);
         end
      end
      tick();
      n_checks++;
      if (pc !== 32'h10) begin
         n_fail++;
         $display("FAIL boot_seq_end: pc=%h, want 00000010", pc);
      end
      $display("reset/boot sequence done, pc=%h", pc);
   endtask

   task automatic test_stall();
      stall = 1'b1; imem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (pc !== 32'h10 || pc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: pc=%h valid=%b, want pc=00000010 valid=1", i, pc, pc_valid);
         end
      end
      stall = 1'b0;
      tick();
      n_checks++;
      if (pc !== 32'h14) begin
         n_fail++;
         $display("FAIL stall_resume: pc=%h, want 00000014", pc);
      end
      $display("stall test done, pc=%h", pc);
   endtask

   task automatic test_branch();
      // Not taken, memory not ready: PC must hold, no flush
      imem_ready = 1'b0;
      ex_valid = 1'b1; ex_instruction = I_BEQ; ex_pc = 32'h20; ex_imm = 32'hFFFF_FFF8; Branch = 1'b0;
      tick();
      n_checks++;
      if (pc !== 32'h14 || flush !== 1'b0 || redirect_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL branch_not_taken: pc=%h flush=%b cnt=%h, want pc=00000014 flush=0 cnt=0", pc, flush, redirect_cnt);
      end
      // Taken while stalled: redirect wins
      Branch = 1'b1; stall = 1'b1;
      tick();
      n_checks++;
      if (flush !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h18 || redirect_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL branch_taken_flush: flush=%b valid=%b pc=%h cnt=%h, want flush=1 valid=0 pc=00000018 cnt=1",
                  flush, pc_valid, pc, redirect_cnt);
      end
      clear_ex(); stall = 1'b0; imem_ready = 1'b1;
      tick();
      n_checks++;
      if (pc !== 32'h18 || pc_valid !== 1'b1 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL branch_target: pc=%h valid=%b flush=%b, want pc=00000018 valid=1 flush=0", pc, pc_valid, flush);
      end
      tick();
      n_checks++;
      if (pc !== 32'h1C) begin
         n_fail++;
         $display("FAIL branch_after: pc=%h, want 0000001c", pc);
      end
      $display("branch test done, pc=%h cnt=%0d", pc, redirect_cnt);
   endtask

   task automatic test_jalr();
      ex_valid = 1'b1; ex_instruction = I_JALR; ex_rs1Data = 32'h1001; ex_imm = 32'h4;
      tick();
      n_checks++;
      if (flush !== 1'b1 || pc !== 32'h1004 || redirect_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL jalr_redirect: flush=%b pc=%h cnt=%h, want flush=1 pc=00001004 cnt=2", flush, pc, redirect_cnt);
      end
      clear_ex();
      tick();
      n_checks++;
      if (pc !== 32'h1004 || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL jalr_target: pc=%h valid=%b, want pc=00001004 valid=1", pc, pc_valid);
      end
      tick();  // pc -> 0x1008
      $display("jalr test done, pc=%h", pc);
   endtask

   task automatic test_ignored();
      // Non-branch opcode with Branch=1
      ex_valid = 1'b1; ex_instruction = I_ADDI; Branch = 1'b1; ex_imm = 32'h40;
      tick();
      n_checks++;
      if (pc !== 32'h100C || flush !== 1'b0 || redirect_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL ignore_nonbranch: pc=%h flush=%b cnt=%h, want pc=0000100c flush=0 cnt=2", pc, flush, redirect_cnt);
      end
      // JALR opcode with nonzero funct3
      ex_instruction = I_JALR_F1; Branch = 1'b0; ex_rs1Data = 32'h2000;
      tick();
      n_checks++;
      if (pc !== 32'h1010 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_jalr_funct3: pc=%h flush=%b, want pc=00001010 flush=0", pc, flush);
      end
      // JAL without ex_valid
      ex_valid = 1'b0; ex_instruction = I_JAL; ex_pc = 32'h3000;
      tick();
      n_checks++;
      if (pc !== 32'h1014 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_bubble: pc=%h flush=%b, want pc=00001014 flush=0", pc, flush);
      end
      clear_ex();
      $display("ignored-redirect test done, pc=%h", pc);
   endtask

   task automatic test_wrap();
      // JAL while memory not ready: redirect still taken
      imem_ready = 1'b0;
      ex_valid = 1'b1; ex_instruction = I_JAL; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC;
      tick();
      n_checks++;
      if (pc !== 32'hFFFF_FFFC || flush !== 1'b1 || redirect_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL jal_redirect: pc=%h flush=%b cnt=%h, want pc=fffffffc flush=1 cnt=3", pc, flush, redirect_cnt);
      end
      clear_ex();
      tick();
      n_checks++;
      if (pc !== 32'hFFFF_FFFC || pc_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL wrap_pre: pc=%h valid=%b, want pc=fffffffc valid=1", pc, pc_valid);
      end
      imem_ready = 1'b1;
      tick();
      n_checks++;
      if (pc !== 32'h0) begin
         n_fail++;
         $display("FAIL wrap: pc=%h, want 00000000", pc);
      end
      $display("wrap test done, pc=%h", pc);
   endtask

   task automatic test_misalign();
      ex_valid = 1'b1; ex_instruction = I_JAL; ex_pc = 32'h100; ex_imm = 32'h2;
      tick();
      n_checks++;
      if (pc !== 32'h100 || flush !== 1'b1 || redirect_cnt !== 16'd4) begin
         n_fail++;
         $display("FAIL misalign_pc: pc=%h flush=%b cnt=%h, want pc=00000100 flush=1 cnt=4", pc, flush, redirect_cnt);
      end
`ifdef PC_MISALIGN_TRAP_EN
      n_checks++;
      if (misalign !== 1'b1 || bad_addr !== 32'h102) begin
         n_fail++;
         $display("FAIL misalign_report: misalign=%b bad_addr=%h, want misalign=1 bad_addr=00000102", misalign, bad_addr);
      end
`endif
      clear_ex();
      tick();
      n_checks++;
      if (pc !== 32'h100 || pc_valid !== 1'b1 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL misalign_after: pc=%h valid=%b flush=%b, want pc=00000100 valid=1 flush=0", pc, pc_valid, flush);
      end
`ifdef PC_MISALIGN_TRAP_EN
      n_checks++;
      if (misalign !== 1'b0 || bad_addr !== 32'h102) begin
         n_fail++;
         $display("FAIL misalign_pulse: misalign=%b bad_addr=%h, want misalign=0 bad_addr=00000102", misalign, bad_addr);
      end
`endif
      $display("misaligned target test done, pc=%h", pc);
   endtask

   task automatic test_saturation();
      stall = 1'b1;
      force dut.redirect_cnt_reg = 16'hFFFF;
      tick();
      release dut.redirect_cnt_reg;
      stall = 1'b0;
      ex_valid = 1'b1; ex_instruction = I_JAL; ex_pc = 32'h200; ex_imm = 32'h0;
      tick();
      n_checks++;
      if (redirect_cnt !== 16'hFFFF || pc !== 32'h200 || flush !== 1'b1) begin
         n_fail++;
         $display("FAIL cnt_saturate: cnt=%h pc=%h flush=%b, want cnt=ffff pc=00000200 flush=1", redirect_cnt, pc, flush);
      end
      clear_ex();
      tick();
      $display("saturation test done, cnt=%h", redirect_cnt);
   endtask

   task automatic test_reset_mid_redirect();
      ex_valid = 1'b1; ex_instruction = I_JAL; ex_pc = 32'h300; ex_imm = 32'h0;
      rst = 1'b1;
      tick();
      n_checks++;
      if (pc !== 32'h0 || pc_valid !== 1'b0 || flush !== 1'b0 || redirect_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_mid_redirect: pc=%h valid=%b flush=%b cnt=%h, want pc=0 valid=0 flush=0 cnt=0",
                  pc, pc_valid, flush, redirect_cnt);
      end
      rst = 1'b0; clear_ex();
      tick();
      n_checks++;
      if (pc !== 32'h0 || pc_valid !== 1'b1 || flush !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_reboot: pc=%h valid=%b flush=%b, want pc=0 valid=1 flush=0", pc, pc_valid, flush);
      end
      $display("reset during redirect test done, pc=%h", pc);
   endtask

   initial begin
      rst = 1'b1; imem_ready = 1'b0; stall = 1'b0;
      clear_ex();
      test_reset();
      test_stall();
      test_branch();
      test_jalr();
      test_ignored();
      test_wrap();
      test_misalign();
      test_saturation();
      test_reset_mid_redirect();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pc_redirect_unit
